// File: rtl/ssd_scan_ctrl.sv
// Scan scheduler for an 8-digit multiplexed seven-segment display with per-frame value snapshot.
// Optional leading-zero blanking is enabled by defining SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] value,
  output logic [7:0]  anode_select,
  output logic [6:0]  segs,
  output logic        frame_start
);

  localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned IDX_W      = 3;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       anode_q, anode_d;
  logic [6:0]       segs_q, segs_d;
  logic             fs_q, fs_d;
  logic [3:0]       nib_d;

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd_q, msd_d;

  // Index of the highest non-zero nibble; 0 when the whole word is zero
  function automatic logic [IDX_W-1:0] find_msd(input logic [31:0] v);
    logic [IDX_W-1:0] m;
    m = '0;
    for (int k = 1; k < 8; k++) begin
      if (v[4*k +: 4] != 4'h0) m = IDX_W'(k);
    end
    return m;
  endfunction
`endif

  // Next-state, counter, snapshot and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;
    fs_d    = 1'b0;
    anode_d = 8'hFF;
    segs_d  = 7'h7F;
    nib_d   = 4'h0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DRIVE;
          cnt_d   = '0;
          idx_d   = '0;
          snap_d  = value;
          fs_d    = 1'b1;
        end
        DRIVE: begin
          if (cnt_q == DIGIT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
            if (idx_q == IDX_W'(7)) begin
              idx_d  = '0;
              snap_d = value;
              fs_d   = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    msd_d = fs_d ? find_msd(snap_d) : msd_q;
`endif

    // Outputs reflect the state being entered so they line up with its first cycle
    if (state_d == DRIVE) begin
      anode_d = ~(8'(1) << idx_d);
      nib_d   = snap_d[{idx_d, 2'b00} +: 4];
      segs_d  = hex_decode(nib_d);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (idx_d > msd_d) segs_d = 7'h7F;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      anode_q <= 8'hFF;
      segs_q  <= 7'h7F;
      fs_q    <= 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      msd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      anode_q <= anode_d;
      segs_q  <= segs_d;
      fs_q    <= fs_d;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      msd_q   <= msd_d;
`endif
    end
  end

  assign anode_select = anode_q;
  assign segs         = segs_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed self-checking bench for ssd_scan_ctrl with DIGIT_CYCLES=4, BLANK_CYCLES=2.
module tb_ssd_scan_ctrl;

  localparam int unsigned DC = 4;
  localparam int unsigned BC = 2;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] value;
  logic [7:0]  anode_select;
  logic [6:0]  segs;
  logic        frame_start;

  int n_vec;
  int n_err;

  ssd_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .value       (value),
    .anode_select(anode_select),
    .segs        (segs),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(negedge clock);
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_anode"}, 32'(anode_select), 32'hFF);
    check_eq({tag, "_segs"}, 32'(segs), 32'h7F);
    check_eq({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  // One frame, starting at the negedge before its first DRIVE cycle.
  // chg_digit: at first cycle of that digit, value becomes chg_val.
  // drop_digit: enable falls at the first BLANK cycle after that digit; task returns.
  task automatic run_frame(input logic [7:0][6:0] es, input int chg_digit,
                           input logic [31:0] chg_val, input int drop_digit);
    logic [7:0] ea;
    for (int d = 0; d < 8; d++) begin
      ea = ~(8'(1) << d);
      for (int c = 0; c < int'(DC); c++) begin
        step();
        check_eq($sformatf("d%0d_c%0d_anode", d, c), 32'(anode_select), 32'(ea));
        check_eq($sformatf("d%0d_c%0d_segs", d, c), 32'(segs), 32'(es[d]));
        check_eq($sformatf("d%0d_c%0d_fs", d, c), 32'(frame_start), (d == 0 && c == 0) ? 32'h1 : 32'h0);
        if (d == chg_digit && c == 0) value = chg_val;
      end
      for (int c = 0; c < int'(BC); c++) begin
        step();
        check_dark($sformatf("d%0d_b%0d", d, c));
        if (d == drop_digit && c == 0) begin
          enable = 1'b0;
          return;
        end
      end
    end
  endtask

  logic [7:0][6:0] pat_a, pat_f, pat_h;
`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic [7:0][6:0] pat_z305, pat_z0;
`endif

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b0;
    enable = 1'b0;
    value  = 32'h7654_3210;
    pat_a  = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    pat_f  = {8{7'h0E}};
    pat_h  = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
`ifdef SSD_LEADING_ZERO_BLANK_EN
    pat_z305 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12};
    pat_z0   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
`endif

    repeat (3) step();
    check_dark("reset");
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      check_dark("idle_pre");
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    value  = 32'h0000_0305;
    enable = 1'b1;
    run_frame(pat_z305, 7, 32'h0, -1);
    run_frame(pat_z0, 7, 32'h7654_3210, -1);
`else
    enable = 1'b1;
    run_frame(pat_a, -1, 32'h0, -1);
`endif
    // Value changes mid-frame stay invisible until the next snapshot
    run_frame(pat_a, 3, 32'hFFFF_FFFF, -1);
    run_frame(pat_f, 1, 32'hFEDC_BA98, -1);
    run_frame(pat_h, -1, 32'h0, -1);

    // Enable drop in BLANK after digit 5, then a fresh restart
    run_frame(pat_h, -1, 32'h0, 5);
    value = 32'h7654_3210;
    for (int i = 0; i < 20; i++) begin
      step();
      check_dark("idle_drop");
    end
    enable = 1'b1;
    run_frame(pat_a, -1, 32'h0, -1);

    // Asynchronous reset in the middle of a DRIVE phase
    step();
    step();
    check_eq("pre_reset_anode", 32'(anode_select), 32'hFE);
    reset = 1'b0;
    #1;
    check_dark("async_reset");
    enable = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_dark("post_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
